// File: rtl/w450_io.sv
// w450_io: memory-mapped I/O responder for the w450 data-side bus.
// Decodes an 8-byte window at IO_BASE and provides a done/halt register,
// a free-running cycle counter, a status register and a small output FIFO.
module w450_io #(
    parameter int             n          = 8,
    parameter logic [n-1:0]   IO_BASE    = 8'hF8,
    parameter int             FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] wr_data,
    input  logic [n-1:0] wr_addr,
    input  logic         wr_en,
    input  logic [n-1:0] rd_addr,
    output logic [n-1:0] rd_data,
    output logic         io_hit,
    output logic [n-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         done,
    output logic [n-1:0] done_code
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] OFF_CYCLE  = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;
    localparam logic [2:0] OFF_OUT    = 3'd6;
    localparam logic [2:0] OFF_DONE   = 3'd7;

    logic [n-1:0]  done_code_reg;
    logic [n-1:0]  cyc_reg;
    logic          overflow_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [n-1:0]  fifo_mem [FIFO_DEPTH];

    logic          wr_hit;
    logic          wr_cycle;
    logic          wr_status;
    logic          wr_out;
    logic          wr_done;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [2:0]    count3;
    logic [n-1:0]  status_word;

    // Write-side address decode; the window is aligned so only the upper bits compare.
    assign wr_hit    = wr_en && (wr_addr[n-1:3] == IO_BASE[n-1:3]);
    assign wr_cycle  = wr_hit && (wr_addr[2:0] == OFF_CYCLE);
    assign wr_status = wr_hit && (wr_addr[2:0] == OFF_STATUS);
    assign wr_out    = wr_hit && (wr_addr[2:0] == OFF_OUT);
    assign wr_done   = wr_hit && (wr_addr[2:0] == OFF_DONE);

    // FIFO handshake: a pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign full      = (count_reg == CW'(FIFO_DEPTH));
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready;
    assign push      = wr_out && (!full || pop);
    assign drop      = wr_out && full && !pop;
    assign out_data  = fifo_mem[rd_ptr_reg];

    // done is simply bit 0 of the last DONE value written.
    assign done      = done_code_reg[0];
    assign done_code = done_code_reg;

    // Done/halt register.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_code_reg <= '0;
        end else if (wr_done) begin
            done_code_reg <= wr_data;
        end
    end

    // Cycle counter: a CYCLE store takes priority over the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_reg <= '0;
        end else if (wr_cycle) begin
            cyc_reg <= wr_data;
        end else if (!done) begin
            cyc_reg <= cyc_reg + 1'b1;
        end
    end

    // Sticky overflow flag; set on a dropped byte, cleared by writing STATUS with the top bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (wr_status && wr_data[n-1]) begin
            overflow_reg <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage: each entry captures the store data when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    fifo_mem[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // STATUS layout: overflow in the top bit, full in bit 3, occupancy in bits 2:0.
    always_comb begin
        count3         = 3'(count_reg);
        status_word    = '0;
        status_word[n-1] = overflow_reg;
        status_word[3]   = full;
        status_word[2:0] = count3;
    end

    // Zero-latency read mux; anything outside the window or in the reserved slots reads 0.
    always_comb begin
        io_hit  = (rd_addr[n-1:3] == IO_BASE[n-1:3]);
        rd_data = '0;
        if (io_hit) begin
            case (rd_addr[2:0])
                OFF_DONE:   rd_data = {{(n-1){1'b0}}, done};
                OFF_STATUS: rd_data = status_word;
                OFF_CYCLE:  rd_data = cyc_reg;
                default:    rd_data = '0;
            endcase
        end
    end

endmodule

// File: doc/w450_io.md
Name: w450_io

Overview:
- Memory-mapped I/O responder on the w450 data-side bus, sitting beside `mem`.
- Observes the processor's store port (st_data/st_addr/st_en) and load address. Decodes the top 8 bytes of the address space (0xF8–0xFF).
- Services those addresses with a done/halt register, a cycle counter, a status register and a buffered output byte stream.
- Top level muxes ld_data to the processor: this block's rd_data when io_hit=1, otherwise `mem` rd1_data.

Parameters:
- n, 8, data and address width in bits.
- IO_BASE, 8'hF8, base of the I/O window; window is IO_BASE..IO_BASE+7; IO_BASE[2:0] must be 0.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_data  in  n  store data (processor st_data).
- wr_addr  in  n  store address (processor st_addr).
- wr_en  in  1  store enable (processor st_en).
- rd_addr  in  n  load address (processor ld_addr).
- rd_data  out  n  load data for I/O addresses (combinational).
- io_hit  out  1  rd_addr lies in the I/O window (combinational).
- out_data  out  n  FIFO head byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream consumer accepts the head byte.
- done  out  1  program-done flag.
- done_code  out  n  last value written to DONE.

Behaviour:
- Register map (offset from IO_BASE):
  - 7 DONE: write sets done<=wr_data[0] and done_code<=wr_data. Read returns {0…, done}.
  - 6 OUT: write pushes wr_data into the FIFO. Read returns 0.
  - 5 STATUS: read returns {overflow, 0…, full, count[2:0]} (bit n-1 = overflow, bit 3 = full, bits 2:0 = count). Writing with wr_data[n-1]=1 clears overflow; other written bits are ignored.
  - 4 CYCLE: read returns cyc. Write loads cyc<=wr_data.
  - 0–3: reserved. Reads return 0; writes are ignored.
- Write decode: an access takes effect at the rising edge where wr_en=1 and wr_addr is in the window. wr_en=1 with an address outside the window has no effect.
- Read path: io_hit and rd_data depend only on rd_addr and current register state, with zero latency. rd_data=0 whenever io_hit=0.
- Cycle counter cyc:
  - Increments by 1 every cycle while done=0, wrapping 255->0.
  - Holds while done=1.
  - A CYCLE write in the same cycle as an increment wins: the loaded value is taken and there is no increment that edge.
- Output FIFO:
  - Circular buffer with read/write pointers and a count in 0..FIFO_DEPTH.
  - out_valid = (count != 0).
  - out_data = head entry; its value is don't-care when empty. Tests must only check out_data while out_valid=1.
  - pop = out_valid & out_ready.
  - push = OUT write & (count < FIFO_DEPTH | pop).
- FIFO boundary cases:
  - Push and pop in the same cycle: count unchanged; both pointers advance. This includes the full case, where the pop frees a slot.
  - OUT write when full with no pop: the byte is dropped, overflow<=1 (sticky), and FIFO contents are unchanged.
  - Pop when empty cannot occur (out_valid=0).
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow set vs clear in the same cycle: a drop (set) and a STATUS clear can never coincide, because there is a single write port.
- Reset: synchronous, active-high, highest priority. Mid-operation it discards FIFO contents and any pending push.
  - Values after reset: done=0, done_code=0, cyc=0, overflow=0, count=0, pointers=0, out_valid=0.
  - Stores presented during reset are ignored.
- DONE: once written, done stays at the written value. Writing DONE with bit0=0 clears done and restarts cyc counting.

Test Plan:
- Reset, then release: cyc reads 1,2,3 on successive cycles at addr 0xFC; io_hit=1 at 0xFC and 0 at 0x80; rd_data=0 at 0x80.
- Store 0x41,0x42,0x43 to 0xFE with out_ready=0 -> STATUS=0x03 and out_valid=1. Raise out_ready -> out_data sequence 0x41,0x42,0x43, then out_valid=0 and STATUS=0x00.
- Overflow:
  - With out_ready=0, store 5 bytes to 0xFE -> STATUS=0x8C (overflow set, full, count=4); the 5th byte is dropped; draining yields only bytes 1–4.
  - Store 0x80 to 0xFD -> STATUS=0x0C.
- Full plus a simultaneous push and pop (out_ready=1 on the push cycle) -> count stays 4, overflow stays 0, the new byte emerges last.
- Store 0x01 to 0xFF at cyc=0x20 -> done=1 and done_code=0x01 on the next edge; cyc frozen at its value on that edge. Store 0x00 to 0xFF -> counting resumes.
- Reset asserted with 3 bytes queued, done=1 and overflow=1 -> next cycle out_valid=0, done=0, STATUS=0x00, cyc=0.
